// File: rtl/sum_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sum_ctrl_pkg
// Shared definitions for the accumulate-loop sequencer:
//   - state_e   : 3-bit FSM state encoding (code 3'd7 is unused)
//   - SEL_*     : datapath mux-select constants
//   - ctrl_t    : bundle of every Moore output of the sequencer
//   - ctrl_decode() : state -> output decode, so the top can register the
//                     outputs one state ahead without duplicating the table
// -----------------------------------------------------------------------------
package sum_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_CHECK = 3'd2,
    ST_ACCUM = 3'd3,
    ST_INCR  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

  // Mux selects shared by the A and Sum source muxes
  localparam logic SEL_ZERO = 1'b0;  // load zero
  localparam logic SEL_NEXT = 1'b1;  // load A+1 / Sum+A

  typedef struct packed {
    logic a_src;
    logic a_load;
    logic sum_src;
    logic sum_load;
    logic out_buf;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

  // Moore output decode; anything not listed for a state stays 0, and the
  // unused encoding decodes like IDLE.
  function automatic ctrl_t ctrl_decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      ST_IDLE: begin
        c = '0;
      end
      ST_INIT: begin
        c.a_src    = SEL_ZERO;
        c.a_load   = 1'b1;
        c.sum_src  = SEL_ZERO;
        c.sum_load = 1'b1;
        c.busy     = 1'b1;
      end
      ST_CHECK: begin
        c.busy = 1'b1;
      end
      ST_ACCUM: begin
        c.sum_src  = SEL_NEXT;
        c.sum_load = 1'b1;
        c.busy     = 1'b1;
      end
      ST_INCR: begin
        c.a_src  = SEL_NEXT;
        c.a_load = 1'b1;
        c.busy   = 1'b1;
      end
      ST_DONE: begin
        c.out_buf = 1'b1;
        c.done    = 1'b1;
        c.busy    = 1'b1;
      end
      ST_ERR: begin
        c.err = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sum_iter_counter.sv
// -----------------------------------------------------------------------------
// sum_iter_counter
// Saturating iteration counter for the accumulate loop.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset (count -> 0)
//   clear_i   in   synchronous clear (wins over inc_i)
//   inc_i     in   increment request; ignored once the count reaches MAX_ITER
//   count_o   out  current count (registered)
//   at_max_o  out  count_o == MAX_ITER
// -----------------------------------------------------------------------------
module sum_iter_counter #(
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              inc_i,
  output logic [ITER_W-1:0] count_o,
  output logic              at_max_o
);

  logic [ITER_W-1:0] count_q;
  logic [ITER_W-1:0] count_d;
  logic              at_max_s;

  assign at_max_s = (count_q == ITER_W'(MAX_ITER));

  // Next count: clear, saturating increment, or hold
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !at_max_s) begin
      count_d = count_q + ITER_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign at_max_o = at_max_s;

endmodule

// File: rtl/sum_loop_ctrl.sv
// -----------------------------------------------------------------------------
// sum_loop_ctrl
// Sequencer for the accumulate datapath (A counter, Sum running total):
//   A=0, Sum=0; while (A < limit) { Sum += A; A += 1; } then publish Sum.
// The datapath does the compare and reports ALtLimit; this block owns the
// start/busy/done handshake, abort and a watchdog on the iteration count.
// Ports:
//   clk, reset             clock / synchronous active-high reset
//   start                  run request, sampled only in IDLE
//   abort                  cancel run or clear error, sampled every cycle
//   ALtLimit               datapath status A < limit
//   ASrcMuxSel, ALoad      A source select (0: zero, 1: A+1) and load
//   SumSrcMuxSel, SumLoad  Sum source select (0: zero, 1: Sum+A) and load
//   OutBufSel              load output buffer from Sum
//   busy, done, err        status; done is a 1-cycle pulse in DONE
//   iter_count             iterations completed in the current/last run
// Outputs are registered from the next-state decode, so each output is valid
// in the same cycle as the state it belongs to (pure Moore timing).
// -----------------------------------------------------------------------------
module sum_loop_ctrl
  import sum_ctrl_pkg::*;
#(
  parameter int MAX_ITER = 255,
  localparam int ITER_W  = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              ALtLimit,
  output logic              ASrcMuxSel,
  output logic              ALoad,
  output logic              SumSrcMuxSel,
  output logic              SumLoad,
  output logic              OutBufSel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_count
);

  state_e            state_q;
  state_e            state_d;
  state_e            nxt_s;
  ctrl_t             ctrl_q;
  logic              cnt_clear_s;
  logic              cnt_inc_s;
  logic              at_max_s;
  logic [ITER_W-1:0] count_s;

  // Counter actions follow the current state so an aborted INIT/INCR still
  // takes effect, matching the A/Sum loads issued in that same cycle.
  assign cnt_clear_s = (state_q == ST_INIT);
  assign cnt_inc_s   = (state_q == ST_INCR);

  sum_iter_counter #(
    .MAX_ITER (MAX_ITER),
    .ITER_W   (ITER_W)
  ) u_iter_counter (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (cnt_clear_s),
    .inc_i    (cnt_inc_s),
    .count_o  (count_s),
    .at_max_o (at_max_s)
  );

  // Next-state decode; abort overrides every transition
  always_comb begin
    nxt_s   = ST_IDLE;
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          nxt_s = ST_INIT;
        end else begin
          nxt_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        nxt_s = ST_CHECK;
      end
      ST_CHECK: begin
        if (!ALtLimit) begin
          nxt_s = ST_DONE;
        end else if (at_max_s) begin
          nxt_s = ST_ERR;
        end else begin
          nxt_s = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        nxt_s = ST_INCR;
      end
      ST_INCR: begin
        nxt_s = ST_CHECK;
      end
      ST_DONE: begin
        nxt_s = ST_IDLE;
      end
      ST_ERR: begin
        nxt_s = ST_ERR;
      end
      default: begin
        nxt_s = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      state_d = nxt_s;
    end
  end

  // State register and outputs registered from the next state's decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_decode(state_d);
    end
  end

  assign ASrcMuxSel   = ctrl_q.a_src;
  assign ALoad        = ctrl_q.a_load;
  assign SumSrcMuxSel = ctrl_q.sum_src;
  assign SumLoad      = ctrl_q.sum_load;
  assign OutBufSel    = ctrl_q.out_buf;
  assign busy         = ctrl_q.busy;
  assign done         = ctrl_q.done;
  assign err          = ctrl_q.err;
  assign iter_count   = count_s;

endmodule
